multi_nibble_addsub_seq: RTL
============================

MULTI_NIBBLE_ADDSUB_SEQ -- requirements
Module: multi_nibble_addsub_seq

Interface
REQ-001 Parameter: NIBBLES, 4, number of 4-bit slices per operand; W = 4*NIBBLES; legal range 2..8.
REQ-002 Clocking: one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  request strobe.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 op_a  input  W  minuend/augend.
REQ-008 op_b  input  W  subtrahend/addend.
REQ-009 op_sub  input  1  1 = A-B, 0 = A+B.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 result  output  W  A+B or A-B mod 2^W.
REQ-013 carry  output  1  final carry out; for subtract, 1 = no borrow.
REQ-014 overflow  output  1  two's-complement overflow of the W-bit operation.
REQ-015 zero  output  1  result == 0.
REQ-016 slc_a, slc_b  output  4 each  operands to the external 4-bit adder/subtractor slice.
REQ-017 slc_cin  output  1  slice Cin; slice computes S = A + (B ^ {4{Cin}}) + Cin.
REQ-018 slc_s  input  4  slice sum; slc_cout  input  1  slice carry; slc_v  input  1  slice signed overflow.

Function
REQ-019 The FSM SHALL have states IDLE, RUN and DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-020 IDLE: when in_valid and in_ready, the block SHALL latch op_a, op_b and op_sub, set nibble index idx=0, set the running carry c=op_sub, and go to RUN.
REQ-021 RUN: per cycle, with a_n = A[4*idx+3:4*idx] and b' = op_sub ? ~B nibble : B nibble, outputs are slc_a=a_n, slc_b = c ? ~b' : b', slc_cin=c, so the slice yields a_n + b' + c.
REQ-022 RUN: each rising edge SHALL write slc_s into result nibble idx, set c<=slc_cout, and increment idx.
REQ-023 At idx==NIBBLES-1, the edge SHALL also set carry<=slc_cout and overflow<=slc_v, compute zero from the final result, and go to DONE.
REQ-024 Latency: out_valid SHALL rise exactly NIBBLES cycles after the accepting edge.
REQ-025 DONE: result, carry, overflow and zero SHALL hold stable until out_valid and out_ready are both high; that edge returns the FSM to IDLE.
REQ-026 in_valid SHALL be ignored in RUN and DONE; there is no request/result overlap, so a new request is accepted no earlier than the cycle after the result handshake.
REQ-027 Outside RUN, slc_a, slc_b and slc_cin SHALL be driven to 0.
REQ-028 Input operand changes after acceptance SHALL NOT affect the operation in progress.

Reset
REQ-029 rst_n low SHALL immediately set state=IDLE, idx=0, c=0, result=0, carry=0, overflow=0, zero=0, out_valid=0, and drive slice outputs to 0; in_ready=1 after release.
REQ-030 Reset asserted in RUN or DONE SHALL abort the operation with no out_valid pulse; the first request after release SHALL compute correctly.

Verification
REQ-031 Add: 0x1234 + 0x0FFF, op_sub=0 -> result 0x2233, carry 0, overflow 0, zero 0; out_valid 4 cycles after the accepting edge.
REQ-032 Signed overflow: 0x7FFF + 0x0001 -> 0x8000, carry 0, overflow 1; 0x8000 - 0x0001 -> 0x7FFF, carry 1, overflow 1.
REQ-033 Borrow: 0x0000 - 0x0001 -> 0xFFFF, carry 0, overflow 0.
REQ-034 Wrap: 0xFFFF + 0x0001 -> 0x0000, carry 1, zero 1.
REQ-035 Backpressure: hold out_ready low 3 cycles in DONE while toggling in_valid and operands -> outputs stable, in_ready 0, nothing accepted; the next request is accepted the cycle after the handshake.
REQ-036 Reset at idx==2 of a subtract -> outputs cleared, no out_valid; then 0x0005 - 0x0003 -> 0x0002, carry 1.

Source files
------------

// File: rtl/multi_nibble_addsub_seq.sv
// Sequential W-bit add/subtract built from one external 4-bit slice, one nibble per cycle,
// with a valid/ready request port and a valid/ready result port.
module multi_nibble_addsub_seq #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] op_a,
  input  logic [4*NIBBLES-1:0] op_b,
  input  logic                 op_sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] result,
  output logic                 carry,
  output logic                 overflow,
  output logic                 zero,
  output logic [3:0]           slc_a,
  output logic [3:0]           slc_b,
  output logic                 slc_cin,
  input  logic [3:0]           slc_s,
  input  logic                 slc_cout,
  input  logic                 slc_v
);

  localparam int unsigned W    = 4 * NIBBLES;
  localparam int unsigned IdxW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q;
  logic [IdxW-1:0] idx_q;
  logic            c_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic            sub_q;
  logic [W-1:0]    result_q;
  logic            carry_q;
  logic            overflow_q;
  logic            zero_q;

  logic [3:0]   a_nib;
  logic [3:0]   b_nib;
  logic [3:0]   b_eff;
  logic [W-1:0] final_res;

  always_comb begin
    a_nib = a_q[{idx_q, 2'b00} +: 4];
    b_nib = b_q[{idx_q, 2'b00} +: 4];
    b_eff = sub_q ? ~b_nib : b_nib;
    // The slice re-inverts B when Cin is set, so pre-invert to make it add b_eff + c.
    if (state_q == StRun) begin
      slc_a   = a_nib;
      slc_b   = c_q ? ~b_eff : b_eff;
      slc_cin = c_q;
    end else begin
      slc_a   = 4'h0;
      slc_b   = 4'h0;
      slc_cin = 1'b0;
    end
    final_res             = result_q;
    final_res[W-1 -: 4]   = slc_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      c_q        <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      sub_q      <= 1'b0;
      result_q   <= '0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q     <= op_a;
            b_q     <= op_b;
            sub_q   <= op_sub;
            idx_q   <= '0;
            c_q     <= op_sub;
            state_q <= StRun;
          end
        end
        StRun: begin
          result_q[{idx_q, 2'b00} +: 4] <= slc_s;
          c_q   <= slc_cout;
          idx_q <= idx_q + IdxW'(1);
          if (idx_q == LastIdx) begin
            carry_q    <= slc_cout;
            overflow_q <= slc_v;
            zero_q     <= (final_res == '0);
            state_q    <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign result    = result_q;
  assign carry     = carry_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;

endmodule
